// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map constants shared by the interrupt controller
package irq_ctrl_pkg;

    localparam logic [2:0] PENDING_OFF = 3'd0;
    localparam logic [2:0] ENABLE_OFF  = 3'd1;
    localparam logic [2:0] MODE_OFF    = 3'd2;
    localparam logic [2:0] ACTIVE_OFF  = 3'd3;
    localparam logic [2:0] RAW_OFF     = 3'd4;

    localparam int ACTIVE_VALID_BIT = 31;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser with previous-value flop for one interrupt line
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // Bring the asynchronous line into the clock domain and remember last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= irq_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/ahbl_irq_ctrl.sv
// rtl/ahbl_irq_ctrl.sv - AHB-Lite interrupt controller with edge/level latching and priority readout
module ahbl_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NIRQ = 8
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic [2:0]      HSIZE,
    input  logic            HWRITE,
    input  logic [31:0]     HWDATA,
    input  logic            HREADY,
    input  logic            HSEL,
    output logic            HREADYOUT,
    output logic [31:0]     HRDATA,
    input  logic [NIRQ-1:0] IRQ_IN,
    output logic            IRQ
);

    logic [NIRQ-1:0] level;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] pending_next;
    logic [NIRQ-1:0] enable;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] mode_next;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] wdata;

    logic       ap_valid;
    logic       ap_write;
    logic [2:0] ap_off;
    logic       wr_en;
    logic       act_valid;
    logic [4:0] act_idx;
    logic [31:0] active_word;

    // Address bits outside the decoded window, size and the transfer sequencing bit are not needed
    logic unused_bus;
    assign unused_bus = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:NIRQ]};

    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_sync
            irq_sync_edge u_sync (
                .clk    (HCLK),
                .rst    (HRESET),
                .irq_in (IRQ_IN[gi]),
                .level  (level[gi]),
                .rise   (rise[gi])
            );
        end
    endgenerate

    assign HREADYOUT = 1'b1;

    // Capture the address phase of a selected, active transfer
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_off   <= 3'd0;
        end else if (HREADY) begin
            ap_valid <= HSEL & HTRANS[1];
            ap_write <= HWRITE;
            ap_off   <= HADDR[4:2];
        end
    end

    assign wr_en     = ap_valid & ap_write;
    assign wdata     = HWDATA[NIRQ-1:0];
    assign clr       = (wr_en && ap_off == PENDING_OFF) ? wdata : '0;
    assign mode_next = (wr_en && ap_off == MODE_OFF) ? wdata : mode;

    // Per-line pending rule; the incoming mode decides so a level-to-edge switch drops the stale level
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (!mode_next[i]) begin
                pending_next[i] = level[i];
            end else if (!mode[i]) begin
                pending_next[i] = rise[i];
            end else begin
                pending_next[i] = rise[i] | (pending[i] & ~clr[i]);
            end
        end
    end

    // Register file update at the end of the data phase, plus the registered request
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
            IRQ     <= 1'b0;
        end else begin
            pending <= pending_next;
            mode    <= mode_next;
            if (wr_en && ap_off == ENABLE_OFF) begin
                enable <= wdata;
            end
            IRQ <= |(pending & enable);
        end
    end

    // Lowest enabled pending index wins
    always_comb begin
        act_valid = 1'b0;
        act_idx   = 5'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pending[i] & enable[i]) begin
                act_valid = 1'b1;
                act_idx   = 5'(i);
            end
        end
    end

    always_comb begin
        active_word = 32'd0;
        if (act_valid) begin
            active_word[ACTIVE_VALID_BIT] = 1'b1;
            active_word[4:0]              = act_idx;
        end
    end

    // Read mux for the data phase; zero outside a valid read
    always_comb begin
        HRDATA = 32'd0;
        if (ap_valid && !ap_write) begin
            case (ap_off)
                PENDING_OFF: HRDATA = 32'(pending);
                ENABLE_OFF:  HRDATA = 32'(enable);
                MODE_OFF:    HRDATA = 32'(mode);
                ACTIVE_OFF:  HRDATA = active_word;
                RAW_OFF:     HRDATA = 32'(level);
                default:     HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_irq_ctrl.sv
// tb/tb_ahbl_irq_ctrl.sv - self-checking bench for ahbl_irq_ctrl
module tb_ahbl_irq_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HSEL = 1'b0;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [7:0]  IRQ_IN = '0;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    ahbl_irq_ctrl #(.NIRQ(8)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .IRQ_IN    (IRQ_IN),
        .IRQ       (IRQ)
    );

    always #5 HCLK = ~HCLK;

    // Reference state: samples of IRQ_IN taken at the last three edges (h0 newest)
    logic [7:0] h0, h1, h2;
    logic [7:0] m_pend, m_en, m_mode;
    logic       m_irq;
    logic       m_av, m_aw;
    logic [2:0] m_aoff;
    logic       m_wr;
    logic [7:0] m_clr, m_nmode;

    assign m_wr    = m_av & m_aw;
    assign m_clr   = (m_wr && m_aoff == 3'd0) ? HWDATA[7:0] : 8'h00;
    assign m_nmode = (m_wr && m_aoff == 3'd2) ? HWDATA[7:0] : m_mode;

    // Pending rule in plain words: level lines follow the synchronised level; a line just
    // switched to edge restarts from a fresh edge only; edge lines set on rise, W1C clears, set wins
    function automatic logic [7:0] next_pend(input logic [7:0] pend, input logic [7:0] old_mode,
                                             input logic [7:0] new_mode, input logic [7:0] s,
                                             input logic [7:0] p, input logic [7:0] clr);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (!new_mode[i])      r[i] = s[i];
            else if (!old_mode[i]) r[i] = s[i] & ~p[i];
            else                   r[i] = (s[i] & ~p[i]) | (pend[i] & ~clr[i]);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [2:0] off);
        logic [31:0] r;
        logic [7:0]  act;
        r   = 32'd0;
        act = m_pend & m_en;
        case (off)
            3'd0: r = {24'd0, m_pend};
            3'd1: r = {24'd0, m_en};
            3'd2: r = {24'd0, m_mode};
            3'd3: begin
                for (int i = 7; i >= 0; i--) begin
                    if (act[i]) r = 32'h8000_0000 | i;
                end
            end
            3'd4: r = {24'd0, h1};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            h0 <= '0; h1 <= '0; h2 <= '0;
            m_pend <= '0; m_en <= '0; m_mode <= '0; m_irq <= 1'b0;
            m_av <= 1'b0; m_aw <= 1'b0; m_aoff <= '0;
        end else begin
            m_irq  <= |(m_pend & m_en);
            m_pend <= next_pend(m_pend, m_mode, m_nmode, h1, h2, m_clr);
            m_mode <= m_nmode;
            if (m_wr && m_aoff == 3'd1) m_en <= HWDATA[7:0];
            h0 <= IRQ_IN; h1 <= h0; h2 <= h1;
            if (HREADY) begin
                m_av   <= HSEL & HTRANS[1];
                m_aw   <= HWRITE;
                m_aoff <= HADDR[4:2];
            end
        end
    end

    // IRQ is tracked against the reference every cycle once the bench is past reset
    always @(negedge HCLK) begin
        if (mon_on && !HRESET) begin
            n_cmp++;
            if (IRQ !== m_irq) begin
                n_bad++;
                $display("FAIL irq_monitor t=%0t got=%0b exp=%0b", $time, IRQ, m_irq);
            end
        end
    end

    task automatic addr_phase(input logic wr, input logic [2:0] off);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = 3'($urandom_range(0, 2));
        HADDR  = {($urandom & 32'hFFFF_FFE0), off, 2'b00};
    endtask

    task automatic idle_addr();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [31:0] d);
        addr_phase(1'b1, off);
        @(negedge HCLK);
        idle_addr();
        HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [31:0] d, output logic [31:0] e);
        addr_phase(1'b0, off);
        @(negedge HCLK);
        idle_addr();
        HWDATA = $urandom;
        d = HRDATA;
        e = exp_reg(off);
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        addr_phase(1'b1, 3'd1);
        @(negedge HCLK);
        idle_addr();
        HWDATA = 32'hFF;
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        for (int o = 0; o < 8; o++) begin
            bus_rd(3'(o), d, e);
            n_cmp++;
            if (d !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_reg off=%0d got=%h exp=%h", o, d, 32'd0);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%0b exp=0", IRQ); end
        n_cmp++;
        if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout got=%0b exp=1", HREADYOUT); end
        n_cmp++;
        if (HRDATA !== 32'd0) begin n_bad++; $display("FAIL idle_hrdata got=%h exp=0", HRDATA); end
    endtask

    task automatic test_edge();
        logic [31:0] d, e;
        bus_wr(3'd2, 32'hFF);
        bus_wr(3'd1, 32'h01);
        repeat (4) @(negedge HCLK);
        IRQ_IN[0] = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        IRQ_IN[0] = 1'b0;
        @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL edge_irq_early got=%0b exp=0", IRQ); end
        @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b1) begin n_bad++; $display("FAIL edge_irq_rise got=%0b exp=1", IRQ); end
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h01) begin n_bad++; $display("FAIL edge_pending got=%h exp=%h", d, 32'h01); end
        bus_rd(3'd3, d, e);
        n_cmp++;
        if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL edge_active got=%h exp=%h", d, 32'h8000_0000); end
        bus_wr(3'd0, 32'h01);
        n_cmp++;
        if (IRQ !== 1'b1) begin n_bad++; $display("FAIL w1c_irq_hold got=%0b exp=1", IRQ); end
        @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL w1c_irq_drop got=%0b exp=0", IRQ); end
    endtask

    task automatic test_level();
        logic [31:0] d, e;
        bus_wr(3'd2, 32'h00);
        bus_wr(3'd1, 32'h04);
        IRQ_IN[2] = 1'b1;
        repeat (5) @(negedge HCLK);
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h04) begin n_bad++; $display("FAIL level_pending got=%h exp=%h", d, 32'h04); end
        bus_wr(3'd0, 32'h04);
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h04) begin n_bad++; $display("FAIL level_w1c_ignored got=%h exp=%h", d, 32'h04); end
        IRQ_IN[2] = 1'b0;
        repeat (3) @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b1) begin n_bad++; $display("FAIL level_irq_hold got=%0b exp=1", IRQ); end
        @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL level_irq_drop got=%0b exp=0", IRQ); end
    endtask

    task automatic test_priority();
        logic [31:0] d, e;
        bus_wr(3'd2, 32'hFF);
        bus_wr(3'd1, 32'hFF);
        IRQ_IN = 8'h28;
        repeat (2) @(negedge HCLK);
        IRQ_IN = 8'h00;
        repeat (4) @(negedge HCLK);
        bus_rd(3'd3, d, e);
        n_cmp++;
        if (d !== 32'h8000_0003) begin n_bad++; $display("FAIL prio_both got=%h exp=%h", d, 32'h8000_0003); end
        bus_wr(3'd0, 32'h08);
        bus_rd(3'd3, d, e);
        n_cmp++;
        if (d !== 32'h8000_0005) begin n_bad++; $display("FAIL prio_after_clr got=%h exp=%h", d, 32'h8000_0005); end
        bus_wr(3'd0, 32'hFF);
        bus_rd(3'd3, d, e);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL prio_none got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_mask_collision();
        logic [31:0] d, e;
        bus_wr(3'd1, 32'h00);
        IRQ_IN[1] = 1'b1;
        repeat (2) @(negedge HCLK);
        IRQ_IN[1] = 1'b0;
        repeat (5) @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL mask_irq got=%0b exp=0", IRQ); end
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h02) begin n_bad++; $display("FAIL mask_pending got=%h exp=%h", d, 32'h02); end
        bus_wr(3'd1, 32'h02);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_bad++; $display("FAIL enable_irq_early got=%0b exp=0", IRQ); end
        @(negedge HCLK);
        n_cmp++;
        if (IRQ !== 1'b1) begin n_bad++; $display("FAIL enable_irq_rise got=%0b exp=1", IRQ); end
        IRQ_IN[1] = 1'b1;
        @(negedge HCLK);
        bus_wr(3'd0, 32'h02);
        IRQ_IN[1] = 1'b0;
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h02) begin n_bad++; $display("FAIL collision_set_wins got=%h exp=%h", d, 32'h02); end
        repeat (3) @(negedge HCLK);
        bus_wr(3'd0, 32'h02);
        bus_rd(3'd0, d, e);
        n_cmp++;
        if (d !== 32'h00) begin n_bad++; $display("FAIL collision_cleanup got=%h exp=%h", d, 32'h00); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e, v;
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, d, e);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
        for (int o = 0; o < 5; o++) begin
            bus_rd(3'(o), d, e);
            n_cmp++;
            if (d !== e) begin n_bad++; $display("FAIL unmapped_side_effect off=%0d got=%h exp=%h", o, d, e); end
        end
        v = $urandom;
        addr_phase(1'b1, 3'd1);
        @(negedge HCLK);
        HWDATA = v;
        addr_phase(1'b0, 3'd1);
        @(negedge HCLK);
        idle_addr();
        d = HRDATA;
        n_cmp++;
        if (d !== {24'd0, v[7:0]}) begin n_bad++; $display("FAIL b2b_enable got=%h exp=%h", d, {24'd0, v[7:0]}); end
        @(negedge HCLK);
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [2:0]  off;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) IRQ_IN = 8'($urandom);
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                bus_wr(off, $urandom);
            end else begin
                bus_rd(off, d, e);
                n_cmp++;
                if (d !== e) begin n_bad++; $display("FAIL random_read k=%0d off=%0d got=%h exp=%h", k, off, d, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        mon_on = 1'b1;
        test_edge();
        test_level();
        test_priority();
        test_mask_collision();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
